// File: rtl/seven_seg_pkg.sv
// Shared types, sizes and segment decode for the multiplexed seven-segment scoreboard.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } conv_state_t;

  localparam int unsigned NumDigits    = 8;
  localparam int unsigned BcdWidth     = 4;
  localparam int unsigned OperandWidth = 27;
  localparam logic [OperandWidth-1:0] MaxDisplay = 27'd99_999_999;

  // Active-low cathodes, bit order {CG..CA}; non-decimal codes go dark.
  function automatic logic [6:0] bcd_to_seg(input logic [BcdWidth-1:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = 7'b1111111;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: 27-bit binary operand to eight BCD digits.
module bin_to_bcd
  import seven_seg_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [OperandWidth-1:0]          bin,
  output logic                             busy,
  output logic                             done,
  output logic [NumDigits*BcdWidth-1:0]    bcd
);

  conv_state_t state, state_next;
  logic [OperandWidth-1:0]       operand;
  logic [NumDigits*BcdWidth-1:0] acc;
  logic [NumDigits*BcdWidth-1:0] adjusted;
  logic [4:0]                    count;

  always_comb begin
    adjusted = acc;
    for (int unsigned i = 0; i < NumDigits; i++) begin
      if (acc[i*BcdWidth +: BcdWidth] >= 4'd5)
        adjusted[i*BcdWidth +: BcdWidth] = acc[i*BcdWidth +: BcdWidth] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (count == 5'(OperandWidth - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand <= '0;
      acc     <= '0;
      count   <= '0;
    end else begin
      case (state)
        LOAD: begin
          operand <= bin;
          acc     <= '0;
          count   <= '0;
        end
        SHIFT: begin
          {acc, operand} <= {adjusted[NumDigits*BcdWidth-2:0], operand, 1'b0};
          count          <= count + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign bcd  = acc;

endmodule

// File: rtl/seven_seg_scoreboard.sv
// Binary score to eight-digit active-low multiplexed display with leading-zero blanking.
`ifndef CLOCK_FREQ_HZ
`define CLOCK_FREQ_HZ 100_000_000
`endif

module seven_seg_scoreboard
  import seven_seg_pkg::*;
#(
  parameter int unsigned ClockFreqHz       = `CLOCK_FREQ_HZ,
  parameter int unsigned RefreshHz         = 1000,
  parameter bit          BlankLeadingZeros = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an
);

  localparam int unsigned DigitCycles = ClockFreqHz / (RefreshHz * NumDigits);
  localparam int unsigned PreWidth    = (DigitCycles > 1) ? $clog2(DigitCycles) : 1;

  if (DigitCycles < 2) begin : g_bad_refresh
    $error("DigitCycles must be at least 2");
  end

  logic [31:0]                   last_value;
  logic                          first;
  logic                          load_q;
  logic                          start;
  logic                          busy;
  logic                          conv_done;
  logic [OperandWidth-1:0]       operand;
  logic [NumDigits*BcdWidth-1:0] conv_bcd;
  logic [NumDigits*BcdWidth-1:0] disp_bcd;
  logic [PreWidth-1:0]           pre;
  logic [2:0]                    idx;
  logic [NumDigits*BcdWidth-1:0] upper;
  logic                          blank;
  logic [7:0]                    an_next;
  logic [6:0]                    seg_next;

  assign start   = !busy && (first || (value != last_value));
  assign operand = (value > 32'(MaxDisplay)) ? MaxDisplay : value[OperandWidth-1:0];

  bin_to_bcd u_bin_to_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (operand),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // load_q marks the converter's LOAD cycle, so last_value tracks exactly the operand it latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_value <= '0;
      first      <= 1'b1;
      load_q     <= 1'b0;
      disp_bcd   <= '0;
    end else begin
      load_q <= start;
      if (load_q) begin
        last_value <= value;
        first      <= 1'b0;
      end
      if (conv_done) disp_bcd <= conv_bcd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PreWidth'(DigitCycles - 1)) begin
      pre <= '0;
      idx <= idx + 3'd1;
    end else begin
      pre <= pre + PreWidth'(1);
    end
  end

  always_comb begin
    upper    = disp_bcd >> {idx, 2'b00};
    blank    = BlankLeadingZeros && (idx != 3'd0) && (upper == '0);
    an_next  = blank ? 8'hFF : ~(8'b1 << idx);
    seg_next = bcd_to_seg(disp_bcd[{idx, 2'b00} +: BcdWidth]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= 1'b1;
    end
  end

endmodule

// File: doc/seven_seg_scoreboard.md
# seven_seg_scoreboard

Drives the eight-digit, active-low, multiplexed seven-segment display from a binary score, such as the `points` output of the game logic. It converts the binary value to BCD with a sequential double-dabble engine and latches the result atomically. It then scans the digits at a fixed refresh rate and blanks leading zeros. It sits in top between the game core and the board pins.

## Interface

**Parameters**
- `ClockFreqHz`, default `` `CLOCK_FREQ_HZ ``: system clock frequency.
- `RefreshHz`, default 1000: full-display refresh rate. Digit period is `DigitCycles = ClockFreqHz / (RefreshHz*8)`. An elaboration assertion requires `DigitCycles >= 2`.
- `BlankLeadingZeros`, default 1: when 1, leading zero digits are blanked.

**Ports**
- `clk` in 1: system clock.
- `rst` in 1: reset. Asynchronous, active-high.
- `value` in 32: binary score.
- `seg` out 7: segment cathodes, active-low. `seg[0]`=CA through `seg[6]`=CG.
- `dp` out 1: decimal point, active-low. Always 1 (off).
- `an` out 8: digit anodes, active-low. `an[0]` is the rightmost digit.

## Operation

**Converter FSM** (`bin_to_bcd`, states IDLE, LOAD, SHIFT, DONE)
- IDLE: if `value != last_value`, or the first-after-reset flag is set, go to LOAD.
- LOAD: capture `value` into `last_value`.
  - Saturate the operand to 99_999_999 if the input exceeds it.
  - Load the 27-bit operand and clear the 32-bit BCD accumulator.
- SHIFT: 27 cycles. Each cycle does two steps:
  - Add 3 to every BCD nibble that is 5 or greater.
  - Shift {bcd, operand} left by 1.
- DONE: one cycle. Copy the accumulator into `disp_bcd[31:0]` in a single write, so the display never shows a partial result. Then go to IDLE.
- Changes to `value` during LOAD, SHIFT or DONE are ignored. IDLE re-compares on the next cycle, so the latest value is always converted eventually.

**Scanner**
- Prescaler counts 0 to `DigitCycles-1`.
- On wrap, digit index `idx` advances 0 to 7 and wraps back to 0.
- Blanking: digit i is blank when all of the following hold:
  - `BlankLeadingZeros` is 1;
  - i is not 0;
  - nibbles i..7 of `disp_bcd` are all 0.
- `an` is all ones except bit `idx` is 0. A blank digit gives `an = 8'hFF`.
- `seg` is the decode of nibble `idx`, active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001;
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000;
  - codes 10–15 give 1111111.

**Reset** (asynchronous)
- `an=8'hFF`, `seg=7'h7F`, `dp=1`.
- `disp_bcd=0`, `idx=0`, prescaler 0.
- FSM goes to IDLE and the first-after-reset flag is set.
- Asserting reset mid-conversion discards the partial result.

## Timing

- `an`, `seg` and `dp` are registered. They change together, one cycle after the cycle where `idx` updates.
- Each digit is driven for exactly `DigitCycles` cycles. One full scan takes `8*DigitCycles` cycles.
- Conversion latency: IDLE detects the change in cycle N, LOAD is N+1, SHIFT runs N+2..N+28, DONE is N+29. `disp_bcd` is valid from N+30. Segment outputs reflect the new value from the first scan slot that begins after that.
- After reset is released, conversion of the current `value` starts on the first clock edge. With `value=0`, digit 0 shows "0" from the first scan slot.
- If `value` changes in the same cycle as DONE, the new value is detected in the following IDLE cycle.

## Structure

- Package `seven_seg_pkg`:
  - `conv_state_t` enum;
  - `NumDigits=8`, `BcdWidth=4`, `MaxDisplay=27'd99_999_999`, `OperandWidth=27`;
  - segment decode function `bcd_to_seg`.
- Sub-module `bin_to_bcd`:
  - ports: `clk`, `rst`, `start`, `bin[26:0]`, `busy`, `done`, `bcd[31:0]`;
  - `done` is a one-cycle pulse with `bcd` valid in that cycle.
  - The top level holds the change-detect and saturation logic, `disp_bcd`, the prescaler and the scanner.

## Test plan

All scenarios use `ClockFreqHz=8000`, `RefreshHz=100`, giving `DigitCycles=10`.

1. **Reset values.** Assert `rst` asynchronously mid-scan → `an=FF`, `seg=7F` and `dp=1` immediately. After release, `idx` restarts at 0.
2. **Value 0.** `value=0` → `an=FE` with `seg=1000000` in digit 0's slot. `an=FF` in every other slot.
3. **Value 1234.** `value=1234` → `disp_bcd` updates exactly 30 cycles after the change. Slots 0..3 show 4, 3, 2, 1 (`an`=FE, FD, FB, F7). Slots 4..7 show `an=FF`.
4. **Saturation and blanking off.** `value=32'd100_000_000` → all eight digits show `seg=0010000` (9). With `BlankLeadingZeros=0` and `value=7`, digits 1..7 show "0".
5. **Change mid-conversion.** `value` changes 5 → 42 at SHIFT cycle 10 → `disp_bcd` shows 5 first, then 42 about 30 cycles after DONE. No intermediate value appears.
6. **Scan cadence.** Over 160 cycles, each `an` pattern is low for exactly 10 consecutive cycles in order 0..7, then 0..7 again. No two `an` bits are ever low at once.
